// File: rtl/tc_fetch_pkg.sv
// Shared constants and types for the instruction-fetch sequencer slice.
package tc_fetch_pkg;

  localparam int ADDR_W       = 16;
  localparam int WORD_W       = 16;
  localparam int PERF_CNT_W   = 32;
  localparam int PERF_FLUSH_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] w3;
    logic [WORD_W-1:0] w2;
    logic [WORD_W-1:0] w1;
    logic [WORD_W-1:0] w0;
  } inst_t;

endpackage

// File: rtl/tc_fetch_sequencer_if.sv
// Memory, redirect and decode-side signals of the fetch sequencer.
// TC_FETCH_PERF_EN adds the performance-counter outputs.
interface tc_fetch_sequencer_if #(
  parameter int BIT_WIDTH = 16
) ();
  import tc_fetch_pkg::*;

  logic                 run;
  logic [ADDR_W-1:0]    mem_addr;
  logic [BIT_WIDTH-1:0] mem_w0;
  logic [BIT_WIDTH-1:0] mem_w1;
  logic [BIT_WIDTH-1:0] mem_w2;
  logic [BIT_WIDTH-1:0] mem_w3;
  logic                 redirect_valid;
  logic [ADDR_W-1:0]    redirect_pc;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [ADDR_W-1:0]    inst_pc;
  logic [BIT_WIDTH-1:0] inst_w0;
  logic [BIT_WIDTH-1:0] inst_w1;
  logic [BIT_WIDTH-1:0] inst_w2;
  logic [BIT_WIDTH-1:0] inst_w3;
  logic                 busy;

`ifdef TC_FETCH_PERF_EN
  logic [PERF_CNT_W-1:0]   perf_fetches;
  logic [PERF_CNT_W-1:0]   perf_stalls;
  logic [PERF_FLUSH_W-1:0] perf_flushes;

  modport master (
    input  run, mem_w0, mem_w1, mem_w2, mem_w3, redirect_valid, redirect_pc, inst_ready,
    output mem_addr, inst_valid, inst_pc, inst_w0, inst_w1, inst_w2, inst_w3, busy,
    output perf_fetches, perf_stalls, perf_flushes
  );
  modport slave (
    output run, mem_w0, mem_w1, mem_w2, mem_w3, redirect_valid, redirect_pc, inst_ready,
    input  mem_addr, inst_valid, inst_pc, inst_w0, inst_w1, inst_w2, inst_w3, busy,
    input  perf_fetches, perf_stalls, perf_flushes
  );
`else
  modport master (
    input  run, mem_w0, mem_w1, mem_w2, mem_w3, redirect_valid, redirect_pc, inst_ready,
    output mem_addr, inst_valid, inst_pc, inst_w0, inst_w1, inst_w2, inst_w3, busy
  );
  modport slave (
    output run, mem_w0, mem_w1, mem_w2, mem_w3, redirect_valid, redirect_pc, inst_ready,
    input  mem_addr, inst_valid, inst_pc, inst_w0, inst_w1, inst_w2, inst_w3, busy
  );
`endif

endinterface

// File: rtl/tc_fetch_fifo.sv
// Small synchronous instruction FIFO; pop is applied before flush, flush wins over push.
module tc_fetch_fifo #(
  parameter int DATA_W = 80,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q;
  logic [PTR_W-1:0]  rd_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_q];
  assign count   = count_q;

  // Storage is reset so the presented instruction reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/tc_fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues 4-word reads, buffers them for decode.
// Optional perf counters are built when TC_FETCH_PERF_EN is defined.
module tc_fetch_sequencer
  import tc_fetch_pkg::*;
#(
  parameter int                BIT_WIDTH  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC   = 16'h0,
  parameter int                PC_STEP    = 4,
  parameter int                FIFO_DEPTH = 2
) (
  input logic                  clk,
  input logic                  rst,
  tc_fetch_sequencer_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]    pc;
    logic [BIT_WIDTH-1:0] w3;
    logic [BIT_WIDTH-1:0] w2;
    logic [BIT_WIDTH-1:0] w1;
    logic [BIT_WIDTH-1:0] w0;
  } entry_t;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              inflight_q;

  logic              pop, push, flush, issue;
  logic [CNT_W:0]    credit;
  logic [CNT_W-1:0]  count;
  logic              full, empty;
  entry_t            push_data, head;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.run) state_d = ST_FETCH;
      ST_FETCH: if (!bus.run) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (bus.run)          state_d = ST_FETCH;
        else if (!inflight_q) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Issue is gated on the state being entered so the first read leaves on the edge run is seen.
  assign pop    = bus.inst_valid && bus.inst_ready;
  assign credit = {1'b0, count} - (CNT_W+1)'(pop) + (CNT_W+1)'(inflight_q);
  assign issue  = (state_d == ST_FETCH) && !bus.redirect_valid && (credit < (CNT_W+1)'(FIFO_DEPTH));
  assign flush  = bus.redirect_valid;
  // A response arriving during a redirect is dropped by the FIFO's flush priority.
  assign push   = inflight_q;

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_valid) pc_d = bus.redirect_pc;
    else if (issue)         pc_d = pc_q + ADDR_W'(PC_STEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      mem_addr_q <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) mem_addr_q <= pc_q;
    end
  end

  // The address register still holds the in-flight PC when its data returns.
  assign push_data = '{pc: mem_addr_q, w3: bus.mem_w3, w2: bus.mem_w2, w1: bus.mem_w1, w0: bus.mem_w0};

  tc_fetch_fifo #(
    .DATA_W ($bits(entry_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign bus.mem_addr   = mem_addr_q;
  assign bus.inst_valid = !empty;
  assign bus.inst_pc    = head.pc;
  assign bus.inst_w0    = head.w0;
  assign bus.inst_w1    = head.w1;
  assign bus.inst_w2    = head.w2;
  assign bus.inst_w3    = head.w3;
  assign bus.busy       = (state_q != ST_IDLE) || inflight_q;

  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !flush && full && !pop));

`ifdef TC_FETCH_PERF_EN
  logic [PERF_CNT_W-1:0]   fetches_q, stalls_q;
  logic [PERF_FLUSH_W-1:0] flushes_q;
  logic                    drops;

  assign drops = bus.redirect_valid && ((count != CNT_W'(pop)) || inflight_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetches_q <= '0;
      stalls_q  <= '0;
      flushes_q <= '0;
    end else begin
      if (issue && (fetches_q != '1)) fetches_q <= fetches_q + 1'b1;
      if (bus.inst_valid && !bus.inst_ready && (stalls_q != '1)) stalls_q <= stalls_q + 1'b1;
      if (drops && (flushes_q != '1)) flushes_q <= flushes_q + 1'b1;
    end
  end

  assign bus.perf_fetches = fetches_q;
  assign bus.perf_stalls  = stalls_q;
  assign bus.perf_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_tc_fetch_sequencer.sv
// Directed vector bench for tc_fetch_sequencer; memory model returns mem[i] = i.
module tb_tc_fetch_sequencer;
  import tc_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  tc_fetch_sequencer_if #(.BIT_WIDTH(16)) bus ();

  tc_fetch_sequencer #(
    .BIT_WIDTH  (16),
    .RESET_PC   (16'h0),
    .PC_STEP    (4),
    .FIFO_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mem_w0 = bus.mem_addr;
  assign bus.mem_w1 = bus.mem_addr + 16'd1;
  assign bus.mem_w2 = bus.mem_addr + 16'd2;
  assign bus.mem_w3 = bus.mem_addr + 16'd3;

  typedef struct {
    logic        run;
    logic        rdy;
    logic        rv;
    logic [15:0] rpc;
    logic        ev;
    inst_t       exp;
    logic        eb;
    logic [15:0] ea;
  } vec_t;

  vec_t vecs[$];

  function automatic inst_t mk_inst(input logic [15:0] pc);
    inst_t r;
    r.pc = pc;
    r.w0 = pc;
    r.w1 = pc + 16'd1;
    r.w2 = pc + 16'd2;
    r.w3 = pc + 16'd3;
    return r;
  endfunction

  task automatic add(input logic run, input logic rdy, input logic rv, input logic [15:0] rpc,
                     input logic ev, input logic [15:0] epc, input logic eb, input logic [15:0] ea);
    vec_t v;
    v.run = run; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.exp = mk_inst(epc); v.eb = eb; v.ea = ea;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_inst(input string tag, input inst_t e);
    chk({tag, " inst_pc"}, bus.inst_pc, e.pc);
    chk({tag, " inst_w0"}, bus.inst_w0, e.w0);
    chk({tag, " inst_w3"}, bus.inst_w3, e.w3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;

    // Stream, back-pressure, redirects, wrap, run fall and drain.
    add(1,1,0,16'h0000, 0,16'h0000, 1,16'h0000);
    add(1,1,0,16'h0000, 1,16'h0000, 1,16'h0004);
    add(1,1,0,16'h0000, 1,16'h0004, 1,16'h0008);
    add(1,1,0,16'h0000, 1,16'h0008, 1,16'h000C);
    add(1,1,0,16'h0000, 1,16'h000C, 1,16'h0010);
    for (int i = 0; i < 5; i++) add(1,0,0,16'h0000, 1,16'h000C, 1,16'h0010);
    add(1,1,0,16'h0000, 1,16'h0010, 1,16'h0014);
    add(1,1,0,16'h0000, 1,16'h0014, 1,16'h0018);
    add(1,1,0,16'h0000, 1,16'h0018, 1,16'h001C);
    add(1,1,1,16'h0100, 0,16'h0000, 1,16'h001C);
    add(1,1,0,16'h0000, 0,16'h0000, 1,16'h0100);
    add(1,1,0,16'h0000, 1,16'h0100, 1,16'h0104);
    add(1,1,0,16'h0000, 1,16'h0104, 1,16'h0108);
    add(1,1,1,16'hFFF8, 0,16'h0000, 1,16'h0108);
    add(1,1,0,16'h0000, 0,16'h0000, 1,16'hFFF8);
    add(1,1,0,16'h0000, 1,16'hFFF8, 1,16'hFFFC);
    add(1,1,0,16'h0000, 1,16'hFFFC, 1,16'h0000);
    add(1,1,0,16'h0000, 1,16'h0000, 1,16'h0004);
    add(0,0,0,16'h0000, 1,16'h0000, 1,16'h0004);
    add(0,0,0,16'h0000, 1,16'h0000, 0,16'h0004);
    add(0,1,0,16'h0000, 1,16'h0004, 0,16'h0004);
    add(0,1,0,16'h0000, 0,16'h0000, 0,16'h0004);
    add(0,1,0,16'h0000, 0,16'h0000, 0,16'h0004);

    bus.run = 1'b0;
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 16'h0;
    tick();
    tick();
    chk("reset inst_valid", bus.inst_valid, 1'b0);
    chk("reset inst_pc", bus.inst_pc, 16'h0);
    chk("reset inst_w0", bus.inst_w0, 16'h0);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset mem_addr", bus.mem_addr, 16'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      bus.run            = vecs[i].run;
      bus.inst_ready     = vecs[i].rdy;
      bus.redirect_valid = vecs[i].rv;
      bus.redirect_pc    = vecs[i].rpc;
      tick();
      chk($sformatf("v%0d inst_valid", i), bus.inst_valid, vecs[i].ev);
      chk($sformatf("v%0d busy", i), bus.busy, vecs[i].eb);
      chk($sformatf("v%0d mem_addr", i), bus.mem_addr, vecs[i].ea);
      if (vecs[i].ev) chk_inst($sformatf("v%0d", i), vecs[i].exp);
    end

    // Asynchronous reset in the middle of a running stream.
    bus.run = 1'b1;
    bus.inst_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst inst_valid", bus.inst_valid, 1'b0);
    chk("midrst inst_pc", bus.inst_pc, 16'h0);
    chk("midrst inst_w3", bus.inst_w3, 16'h0);
    chk("midrst busy", bus.busy, 1'b0);
    chk("midrst mem_addr", bus.mem_addr, 16'h0);
`ifdef TC_FETCH_PERF_EN
    chk("midrst perf_fetches", bus.perf_fetches, 32'd0);
    chk("midrst perf_stalls", bus.perf_stalls, 32'd0);
    chk("midrst perf_flushes", bus.perf_flushes, 32'd0);
`endif
    tick();
    bus.inst_ready = 1'b0;
    rst = 1'b0;

    // Bounded wait for the first instruction after reset release.
    cycles = 0;
    while (!bus.inst_valid && cycles < 6) begin
      tick();
      cycles++;
    end
    chk("restart first-valid latency", cycles, 2);
    chk_inst("restart", mk_inst(16'h0000));

    tick();
    tick();
    tick();
    chk("stall mem_addr", bus.mem_addr, 16'h0004);
`ifdef TC_FETCH_PERF_EN
    chk("perf_stalls after 3", bus.perf_stalls, 32'd3);
    chk("perf_fetches", bus.perf_fetches, 32'd2);
`endif

    // Redirect together with run falling: pc loads, machine drains to idle.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'h0040;
    bus.run = 1'b0;
    tick();
    bus.redirect_valid = 1'b0;
    chk("redir+stop inst_valid", bus.inst_valid, 1'b0);
    chk("redir+stop busy", bus.busy, 1'b1);
    chk("redir+stop mem_addr", bus.mem_addr, 16'h0004);
`ifdef TC_FETCH_PERF_EN
    chk("perf_flushes", bus.perf_flushes, 32'd1);
`endif
    tick();
    chk("redir+stop idle busy", bus.busy, 1'b0);
    bus.run = 1'b1;
    bus.inst_ready = 1'b1;
    tick();
    chk("resume mem_addr", bus.mem_addr, 16'h0040);
    tick();
    chk("resume inst_valid", bus.inst_valid, 1'b1);
    chk_inst("resume", mk_inst(16'h0040));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
